// File: rtl/run_detect_moore_if.sv
// Signal bundle for the run-length detector: sampling controls in, detect status out.
// The master side drives the serial stream and controls; the slave side is the detector.
interface run_detect_moore_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned RW = $clog2(N + 1);

    logic            en;
    logic            w;
    logic [1:0]      mode;
    logic            overlap;
    logic            clr;
    logic            F;
    logic            F_val;
    logic [RW-1:0]   run_len;
    logic [CNT_W-1:0] det_cnt;

    modport master (
        output en, w, mode, overlap, clr,
        input  F, F_val, run_len, det_cnt
    );

    modport slave (
        input  en, w, mode, overlap, clr,
        output F, F_val, run_len, det_cnt
    );
endinterface

// File: rtl/run_detect_moore.sv
// Parametrised Moore run-length detector: flags N equal consecutive enabled samples,
// with polarity select, overlap control and a saturating detection counter.
module run_detect_moore #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 8
) (
    input logic              CLK,
    input logic              RST,
    run_detect_moore_if.slave bus
);
    localparam int unsigned RW = $clog2(N + 1);

    localparam logic [RW-1:0]    RunOne = RW'(1);
    localparam logic [RW-1:0]    RunPre = RW'(N - 1);
    localparam logic [RW-1:0]    RunMax = RW'(N);
    localparam logic [CNT_W-1:0] CntMax = '1;

    if (N < 2) begin : g_bad_n
        $error("run_detect_moore: N must be at least 2");
    end

    typedef enum logic [0:0] {StIdle, StTrack} state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [RW-1:0]    run_q, run_d;
    logic             f_q, f_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             det_event;

    function automatic logic match(input logic [1:0] m, input logic b);
        logic r;
        case (m)
            2'b00:   r = 1'b1;
            2'b01:   r = b;
            2'b10:   r = ~b;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        run_d   = run_q;
        if (bus.en) begin
            unique case (state_q)
                StIdle: begin
                    state_d = StTrack;
                    last_d  = bus.w;
                    run_d   = RunOne;
                end
                StTrack: begin
                    if (bus.w != last_q) begin
                        last_d = bus.w;
                        run_d  = RunOne;
                    end else if (run_q < RunMax) begin
                        run_d = run_q + RunOne;
                    end else begin
                        run_d = bus.overlap ? RunMax : RunOne;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // F is re-evaluated every edge so mode changes land even while en is low.
    always_comb begin
        f_d       = (run_d == RunMax) && match(bus.mode, last_d);
        det_event = bus.en && (run_q == RunPre) && (run_d == RunMax) && match(bus.mode, last_d);
        cnt_d     = cnt_q;
        if (bus.clr) begin
            cnt_d = '0;
        end else if (det_event && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            last_q  <= 1'b0;
            run_q   <= '0;
            f_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            run_q   <= run_d;
            f_q     <= f_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.F       = f_q;
    assign bus.F_val   = last_q;
    assign bus.run_len = run_q;
    assign bus.det_cnt = cnt_q;

    a_run_bounded : assert property (@(posedge CLK) disable iff (!RST) run_q <= RunMax);
    a_flag_full   : assert property (@(posedge CLK) disable iff (!RST) f_q |-> run_q == RunMax);
    a_disabled    : assert property (@(posedge CLK) disable iff (!RST)
                                     bus.mode == 2'b11 |=> !f_q);
endmodule

// File: tb/tb_run_detect_moore.sv
// Directed bench for run_detect_moore: stimulus pushes expectations into a queue and a
// monitor on the falling clock edge pops and compares them against the DUT outputs.
module tb_run_detect_moore;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    run_detect_moore_if #(.N(4), .CNT_W(8)) bus_a ();
    run_detect_moore_if #(.N(4), .CNT_W(2)) bus_b ();

    assign bus_b.en      = bus_a.en;
    assign bus_b.w       = bus_a.w;
    assign bus_b.mode    = bus_a.mode;
    assign bus_b.overlap = bus_a.overlap;
    assign bus_b.clr     = bus_a.clr;

    run_detect_moore #(.N(4), .CNT_W(8)) dut_a (.CLK(CLK), .RST(RST), .bus(bus_a));
    run_detect_moore #(.N(4), .CNT_W(2)) dut_b (.CLK(CLK), .RST(RST), .bus(bus_b));

    typedef struct {
        string nm;
        logic  f;
        logic  fv;
        int    rl;
        int    cnt;
        bit    chk_b;
        int    cntb;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [1:0] md = 2'b00;
    logic       ov = 1'b1;
    logic       cl = 1'b0;

    // One enabled/disabled sample: drive at negedge, queue the post-edge expectation.
    task automatic step(input logic e, input logic wb, input string nm, input logic f,
                        input logic fv, input int rl, input int cnt,
                        input bit cb = 1'b0, input int cntb = 0);
        exp_t ex;
        @(negedge CLK);
        bus_a.en      = e;
        bus_a.w       = wb;
        bus_a.mode    = md;
        bus_a.overlap = ov;
        bus_a.clr     = cl;
        @(posedge CLK);
        ex = '{nm, f, fv, rl, cnt, cb, cntb};
        exp_q.push_back(ex);
    endtask

    task automatic check_reset(input string nm);
        n_checks++;
        if (bus_a.F !== 1'b0 || bus_a.F_val !== 1'b0 || bus_a.run_len !== 3'd0 ||
            bus_a.det_cnt !== 8'd0 || bus_b.det_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL %s: got F=%b F_val=%b run_len=%0d det_cnt=%0d cnt_b=%0d, want all 0",
                     nm, bus_a.F, bus_a.F_val, bus_a.run_len, bus_a.det_cnt, bus_b.det_cnt);
        end
    endtask

    always @(negedge CLK) begin
        if (RST && exp_q.size() > 0) begin
            exp_t ex;
            ex = exp_q.pop_front();
            n_checks++;
            if (bus_a.F !== ex.f || bus_a.F_val !== ex.fv || int'(bus_a.run_len) != ex.rl ||
                int'(bus_a.det_cnt) != ex.cnt ||
                (ex.chk_b && int'(bus_b.det_cnt) != ex.cntb)) begin
                n_fail++;
                $display("FAIL %s: got F=%b F_val=%b run_len=%0d det_cnt=%0d cnt_b=%0d, want F=%b F_val=%b run_len=%0d det_cnt=%0d cnt_b=%0d",
                         ex.nm, bus_a.F, bus_a.F_val, bus_a.run_len, bus_a.det_cnt,
                         bus_b.det_cnt, ex.f, ex.fv, ex.rl, ex.cnt, ex.cntb);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.en      = 1'b0;
        bus_a.w       = 1'b0;
        bus_a.mode    = 2'b00;
        bus_a.overlap = 1'b1;
        bus_a.clr     = 1'b0;

        // Asynchronous reset before any clock edge.
        #3 RST = 1'b0;
        #1 check_reset("reset_async");
        repeat (3) begin
            @(negedge CLK);
            bus_a.en = 1'($urandom);
            bus_a.w  = 1'($urandom);
        end
        #2 check_reset("reset_held");
        @(negedge CLK);
        bus_a.en = 1'b0;
        RST      = 1'b1;

        // Overlapping run of six ones.
        md = 2'b00; ov = 1'b1; cl = 1'b0;
        step(1'b1, 1'b1, "rst_first", 1'b0, 1'b1, 1, 0);
        for (int i = 2; i <= 6; i++)
            step(1'b1, 1'b1, "ovl_run", i >= 4, 1'b1, (i < 4) ? i : 4, (i >= 4) ? 1 : 0);
        step(1'b1, 1'b0, "ovl_break", 1'b0, 1'b0, 1, 1);

        // Non-overlapping run of eight zeros.
        ov = 1'b0;
        step(1'b1, 1'b1, "nov_prep", 1'b0, 1'b1, 1, 1);
        for (int i = 1; i <= 8; i++)
            step(1'b1, 1'b0, "nov_run", (i % 4) == 0, 1'b0, ((i - 1) % 4) + 1,
                 (i >= 8) ? 3 : ((i >= 4) ? 2 : 1));

        // Mode filtering.
        md = 2'b01;
        step(1'b1, 1'b1, "mf_prep", 1'b0, 1'b1, 1, 3);
        for (int i = 1; i <= 4; i++)
            step(1'b1, 1'b0, "mf_ones_only", 1'b0, 1'b0, i, 3);
        md = 2'b00;
        step(1'b0, 1'b0, "mf_either_en0", 1'b1, 1'b0, 4, 3);
        md = 2'b11;
        step(1'b0, 1'b0, "mf_disabled", 1'b0, 1'b0, 4, 3);

        // Enable gaps inside a run.
        md = 2'b00; ov = 1'b1;
        step(1'b1, 1'b1, "gap_s1", 1'b0, 1'b1, 1, 3);
        step(1'b1, 1'b1, "gap_s2", 1'b0, 1'b1, 2, 3);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, "gap_idle", 1'b0, 1'b1, 2, 3);
        step(1'b1, 1'b1, "gap_s3", 1'b0, 1'b1, 3, 3);
        step(1'b1, 1'b1, "gap_det", 1'b1, 1'b1, 4, 4);

        // Mid-run reset discards a partial run of three ones.
        step(1'b1, 1'b0, "pre_rst_flip", 1'b0, 1'b0, 1, 4);
        for (int i = 1; i <= 3; i++)
            step(1'b1, 1'b1, "pre_rst_run", 1'b0, 1'b1, i, 4);
        @(negedge CLK);
        #2;
        RST      = 1'b0;
        bus_a.en = 1'b0;
        #1 check_reset("reset_mid_run");
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 1; i <= 4; i++)
            step(1'b1, 1'b1, "post_rst", i == 4, 1'b1, i, (i == 4) ? 1 : 0, 1'b1,
                 (i == 4) ? 1 : 0);

        // Counter saturation on the narrow instance.
        ov = 1'b0;
        for (int k = 1; k <= 16; k++)
            step(1'b1, 1'b1, "sat", (k % 4) == 0, 1'b1, ((k - 1) % 4) + 1, 1 + k / 4, 1'b1,
                 (1 + k / 4 > 3) ? 3 : 1 + k / 4);

        // Clear wins over a simultaneous detection.
        for (int i = 1; i <= 3; i++)
            step(1'b1, 1'b1, "clr_run", 1'b0, 1'b1, i, 5, 1'b1, 3);
        cl = 1'b1;
        step(1'b1, 1'b1, "clr_det", 1'b1, 1'b1, 4, 0, 1'b1, 0);
        cl = 1'b0;
        step(1'b1, 1'b1, "after_clr", 1'b0, 1'b1, 1, 0, 1'b1, 0);

        repeat (2) @(negedge CLK);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
